// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the data-side memory bus controller: FSM encoding,
// address-decode result type, default address map and the decode helper.
`timescale 1ns/1ps
package mem_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RAM_RD = 2'd1,
      ST_IO_REQ = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DEC_NONE = 2'd0,
      DEC_RAM  = 2'd1,
      DEC_IO   = 2'd2
   } dec_t;

   localparam int unsigned DEF_RAM_ADDR_W     = 16;
   localparam logic [31:0] DEF_IO_BASE        = 32'h1fd0_0000;
   localparam int unsigned DEF_IO_ADDR_W      = 16;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

   // The MMIO window is tested first so it wins if it ever overlaps RAM.
   function automatic dec_t decode(input logic [31:0] addr, input logic [31:0] io_base,
                                   input int unsigned io_w, input int unsigned ram_w);
      if ((addr >> io_w) == (io_base >> io_w)) return DEC_IO;
      if ((addr >> (ram_w + 2)) == 32'd0) return DEC_RAM;
      return DEC_NONE;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_watchdog.sv
// MMIO watchdog (counter + expiry flag); only built when MEM_BUS_TIMEOUT_EN is defined,
// otherwise this file contributes no module at all.
`timescale 1ns/1ps
`ifdef MEM_BUS_TIMEOUT_EN
module mem_bus_watchdog
   import mem_bus_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic cnt_en_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count holds N-1 during the Nth waiting cycle, so expiry fires in that cycle.
   assign expired_o = cnt_en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (cnt_en_i && !expired_o)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule
`endif

// File: rtl/mem_bus_ctrl.sv
// Data-side memory controller: decodes RAM / MMIO / unmapped, runs the 1-cycle RAM
// read and the MMIO valid/ready handshake, and stalls the pipeline until done.
// Optional MMIO timeout with bus_error pulse: define MEM_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int unsigned RAM_ADDR_W     = DEF_RAM_ADDR_W,
   parameter logic [31:0] IO_BASE        = DEF_IO_BASE,
   parameter int unsigned IO_ADDR_W      = DEF_IO_ADDR_W,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_en,
   input  logic [3:0]            req_wen,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic [31:0]           req_rdata,
   output logic                  stall,
   output logic                  ram_en,
   output logic [3:0]            ram_wen,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata,
   output logic                  io_valid,
   input  logic                  io_ready,
   output logic [3:0]            io_wen,
   output logic [IO_ADDR_W-1:0]  io_addr,
   output logic [31:0]           io_wdata,
   input  logic [31:0]           io_rdata,
   output logic                  bus_error,
   output logic [1:0]            dbg_state
);

   // MMIO handshake: io_valid is held with io_addr/io_wen/io_wdata stable until the
   // cycle io_ready is seen high; that cycle completes the access and samples io_rdata.

   state_t               state_q, state_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [3:0]           io_wen_q, io_wen_d;
   logic [IO_ADDR_W-1:0] io_addr_q, io_addr_d;
   logic [31:0]          io_wdata_q, io_wdata_d;
   logic                 stall_c, ram_en_c, io_valid_c;
   logic [3:0]           ram_wen_c;
   logic                 expired;
   dec_t                 dec;

   assign dec = decode(req_addr, IO_BASE, IO_ADDR_W, RAM_ADDR_W);

`ifdef MEM_BUS_TIMEOUT_EN
   logic err_q, err_d;

   mem_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     ((state_q == ST_IDLE) && (state_d == ST_IO_REQ)),
      .cnt_en_i  (state_q == ST_IO_REQ),
      .expired_o (expired)
   );

   assign err_d     = (state_q == ST_IO_REQ) ? (expired && !io_ready) : err_q;
   assign bus_error = rst && (state_q == ST_DONE) && err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end
`else
   assign expired   = 1'b0;
   assign bus_error = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      rdata_d    = rdata_q;
      io_wen_d   = io_wen_q;
      io_addr_d  = io_addr_q;
      io_wdata_d = io_wdata_q;
      stall_c    = 1'b0;
      ram_en_c   = 1'b0;
      ram_wen_c  = 4'h0;
      io_valid_c = 1'b0;
      req_rdata  = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (req_en) begin
               case (dec)
                  DEC_IO: begin
                     stall_c    = 1'b1;
                     io_addr_d  = req_addr[IO_ADDR_W-1:0];
                     io_wen_d   = req_wen;
                     io_wdata_d = req_wdata;
                     state_d    = ST_IO_REQ;
                  end
                  DEC_RAM: begin
                     ram_en_c  = 1'b1;
                     ram_wen_c = req_wen;
                     // Writes retire in the same cycle; only reads wait for RAM data.
                     if (req_wen == 4'h0) begin
                        stall_c = 1'b1;
                        state_d = ST_RAM_RD;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_RAM_RD: begin
            req_rdata = ram_rdata;
            state_d   = ST_IDLE;
         end
         ST_IO_REQ: begin
            io_valid_c = 1'b1;
            stall_c    = 1'b1;
            if (io_ready) begin
               rdata_d = io_rdata;
               state_d = ST_DONE;
            end else if (expired) begin
               rdata_d = 32'h0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            req_rdata = rdata_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         rdata_q    <= 32'h0;
         io_wen_q   <= 4'h0;
         io_addr_q  <= '0;
         io_wdata_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         rdata_q    <= rdata_d;
         io_wen_q   <= io_wen_d;
         io_addr_q  <= io_addr_d;
         io_wdata_q <= io_wdata_d;
      end
   end

   // Strobes are gated by reset so an in-flight access drops the moment rst falls.
   assign stall     = rst && stall_c;
   assign ram_en    = rst && ram_en_c;
   assign ram_wen   = rst ? ram_wen_c : 4'h0;
   assign io_valid  = rst && io_valid_c;
   assign ram_addr  = req_addr[RAM_ADDR_W+1:2];
   assign ram_wdata = req_wdata;
   assign io_wen    = io_wen_q;
   assign io_addr   = io_addr_q;
   assign io_wdata  = io_wdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: table of single-access RAM/unmapped vectors,
// random RAM traffic, hand-written MMIO, reset-abandon and (with MEM_BUS_TIMEOUT_EN) timeout sequences.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_en = 1'b0;
   logic [3:0]  req_wen = 4'h0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [31:0] req_rdata;
   logic        stall;
   logic        ram_en;
   logic [3:0]  ram_wen;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'h0;
   logic        io_valid;
   logic        io_ready = 1'b0;
   logic [3:0]  io_wen;
   logic [15:0] io_addr;
   logic [31:0] io_wdata;
   logic [31:0] io_rdata = 32'h0;
   logic        bus_error;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   mem_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .req_en(req_en), .req_wen(req_wen), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rdata(req_rdata), .stall(stall), .ram_en(ram_en),
      .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .io_valid(io_valid), .io_ready(io_ready), .io_wen(io_wen), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .bus_error(bus_error), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: sim still running at %0t, required finish", $time);
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_resp(input string name);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got %h want <empty queue>", name, req_rdata);
      end else begin
         e = exp_q.pop_front();
         chk(name, req_rdata, e);
      end
   endtask

   typedef struct {
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] ram_rd;
      logic        e_ram_en;
      logic        e_stall;
      logic [31:0] e_rdata;
   } vec_t;

   function automatic vec_t mk(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] ram_rd,
                               input logic e_ram_en, input logic e_stall, input logic [31:0] e_rdata);
      vec_t v;
      v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata; v.ram_rd = ram_rd;
      v.e_ram_en = e_ram_en; v.e_stall = e_stall; v.e_rdata = e_rdata;
      return v;
   endfunction

   // One access from IDLE; RAM reads take one extra cycle, everything else retires at once.
   task automatic apply_vec(input vec_t v, input string tag);
      logic [15:0] exp_wa;
      exp_wa = v.addr[17:2];
      @(negedge clk);
      req_en = v.en; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
      ram_rdata = $urandom;
      #1;
      chk({tag, "_ram_en"}, ram_en, v.e_ram_en);
      chk({tag, "_ram_wen"}, ram_wen, v.e_ram_en ? v.wen : 4'h0);
      chk({tag, "_stall"}, stall, v.e_stall);
      chk({tag, "_io_valid"}, io_valid, 1'b0);
      if (v.e_ram_en) begin
         chk({tag, "_ram_addr"}, ram_addr, exp_wa);
         chk({tag, "_ram_wdata"}, ram_wdata, v.wdata);
      end
      if (v.en && (v.wen == 4'h0)) exp_q.push_back(v.e_rdata);
      if (v.en && (v.wen == 4'h0) && !v.e_stall) chk_resp({tag, "_rdata_now"});
      if (v.e_stall) begin
         @(negedge clk);
         ram_rdata = v.ram_rd;
         #1;
         chk({tag, "_rd_stall"}, stall, 1'b0);
         chk({tag, "_rd_ram_en"}, ram_en, 1'b0);
         chk_resp({tag, "_rd_rdata"});
      end
      @(negedge clk);
      req_en = 1'b0; req_wen = 4'h0;
      #1;
      chk({tag, "_idle_stall"}, stall, 1'b0);
      chk({tag, "_idle_state"}, dbg_state, 2'd0);
   endtask

   // rdy_at: io_valid cycle (1-based) on which io_ready is raised; 0 = never.
   task automatic io_access(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                            input int rdy_at, input logic [31:0] rdat, input int n_valid,
                            input logic exp_err, input logic [31:0] exp_data, input string tag);
      int stall_cnt;
      stall_cnt = 0;
      @(negedge clk);
      req_en = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
      #1;
      chk({tag, "_issue_stall"}, stall, 1'b1);
      chk({tag, "_issue_valid"}, io_valid, 1'b0);
      chk({tag, "_issue_ram_en"}, ram_en, 1'b0);
      stall_cnt += int'(stall);
      exp_q.push_back(exp_data);
      for (int c = 1; c <= n_valid; c++) begin
         @(negedge clk);
         io_ready = (c == rdy_at);
         io_rdata = (c == rdy_at) ? rdat : $urandom;
         #1;
         chk({tag, "_valid"}, io_valid, 1'b1);
         chk({tag, "_addr"}, io_addr, addr[15:0]);
         chk({tag, "_wen"}, io_wen, wen);
         chk({tag, "_wdata"}, io_wdata, wdata);
         chk({tag, "_err_wait"}, bus_error, 1'b0);
         stall_cnt += int'(stall);
      end
      @(negedge clk);
      io_ready = 1'b0;
      #1;
      chk({tag, "_done_valid"}, io_valid, 1'b0);
      chk({tag, "_done_stall"}, stall, 1'b0);
      chk({tag, "_done_err"}, bus_error, exp_err);
      chk_resp({tag, "_done_rdata"});
      chk({tag, "_stall_cycles"}, stall_cnt, n_valid + 1);
      @(negedge clk);
      req_en = 1'b0; req_wen = 4'h0;
      #1;
      chk({tag, "_after_err"}, bus_error, 1'b0);
      chk({tag, "_after_valid"}, io_valid, 1'b0);
      chk({tag, "_after_state"}, dbg_state, 2'd0);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = mk(1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0);
      vecs[1] = mk(1'b1, 4'hf, 32'h0000_0010, 32'h1234_5678, 32'h0,         1'b1, 1'b0, 32'h0);
      vecs[2] = mk(1'b1, 4'h1, 32'h0003_fffc, 32'h0000_00ab, 32'h0,         1'b1, 1'b0, 32'h0);
      vecs[3] = mk(1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'hcafe_0001, 1'b1, 1'b1, 32'hcafe_0001);
      vecs[4] = mk(1'b1, 4'h0, 32'h0003_fffc, 32'h0,         32'hdead_beef, 1'b1, 1'b1, 32'hdead_beef);
      vecs[5] = mk(1'b1, 4'h0, 32'h4000_0000, 32'h0,         32'h5555_5555, 1'b0, 1'b0, 32'h0);
      vecs[6] = mk(1'b1, 4'hf, 32'h0004_0000, 32'hffff_ffff, 32'h0,         1'b0, 1'b0, 32'h0);
      vecs[7] = mk(1'b1, 4'h0, 32'h1fcf_fffc, 32'h0,         32'h7777_0000, 1'b0, 1'b0, 32'h0);
      vecs[8] = mk(1'b1, 4'h0, 32'h1fd1_0000, 32'h0,         32'h7777_0001, 1'b0, 1'b0, 32'h0);
      vecs[9] = mk(1'b1, 4'hc, 32'h0000_0000, 32'h8765_4321, 32'h0,         1'b1, 1'b0, 32'h0);

      // Reset with a RAM read presented: strobes must stay low.
      req_en = 1'b1; req_addr = 32'h0000_0020; req_wen = 4'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_ram_en", ram_en, 1'b0);
      chk("rst_io_valid", io_valid, 1'b0);
      chk("rst_bus_error", bus_error, 1'b0);
      chk("rst_io_addr", io_addr, 16'h0);
      chk("rst_io_wen", io_wen, 4'h0);
      chk("rst_io_wdata", io_wdata, 32'h0);
      chk("rst_state", dbg_state, 2'd0);
      @(negedge clk);
      req_en = 1'b0;
      rst = 1'b1;

      for (int i = 0; i < 10; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 16; i++) begin
         vec_t v;
         logic [3:0]  w;
         logic [31:0] d;
         w = (i % 2 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         d = $urandom;
         v = mk(1'b1, w, {14'h0, 16'($urandom_range(0, 16'hffff)), 2'b00}, $urandom, d,
                1'b1, (w == 4'h0), (w == 4'h0) ? d : 32'h0);
         apply_vec(v, $sformatf("rnd%0d", i));
      end

      io_access(32'h1fd0_0008, 4'h0, 32'h0, 3, 32'ha5a5_0001, 3, 1'b0, 32'ha5a5_0001, "io_rd3");
      io_access(32'h1fd0_fffc, 4'h3, 32'h0bad_cafe, 1, 32'h1111_2222, 1, 1'b0, 32'h1111_2222, "io_wr1");
`ifndef MEM_BUS_TIMEOUT_EN
      io_access(32'h1fd0_0040, 4'h0, 32'h0, 12, 32'h3c3c_0f0f, 12, 1'b0, 32'h3c3c_0f0f, "io_rd12");
`endif

      // Reset during IO_REQ abandons the access.
      @(negedge clk);
      req_en = 1'b1; req_wen = 4'hf; req_addr = 32'h1fd0_0100; req_wdata = 32'h0102_0304;
      @(negedge clk);
      req_addr = 32'h0000_0020; req_wen = 4'h0;
      #1;
      chk("rstmid_valid_before", io_valid, 1'b1);
      rst = 1'b0;
      #1;
      chk("rstmid_valid", io_valid, 1'b0);
      chk("rstmid_stall", stall, 1'b0);
      chk("rstmid_ram_en", ram_en, 1'b0);
      chk("rstmid_io_addr", io_addr, 16'h0);
      @(negedge clk);
      req_en = 1'b0;
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("rstmid_no_replay", io_valid, 1'b0);
      end
      apply_vec(mk(1'b1, 4'h0, 32'h0000_0020, 32'h0, 32'h0bad_f00d, 1'b1, 1'b1, 32'h0bad_f00d), "rstmid_ram");

`ifdef MEM_BUS_TIMEOUT_EN
      io_access(32'h1fd0_0004, 4'h0, 32'h0, 0, 32'h0, 8, 1'b1, 32'h0, "to_expire");
      io_access(32'h1fd0_0004, 4'h0, 32'h0, 8, 32'h1234_abcd, 8, 1'b0, 32'h1234_abcd, "to_race");
`endif

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
